dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Memory-stage sequencer for the pipelined RV32I core. Takes the load/store command held in the EX/M pipeline register and runs it as a valid/ready transaction on a multi-cycle data-memory port. It freezes the pipeline with `stall_M` while the access is outstanding. It also generates byte strobes and lane-replicated write data, and aligns and extends load data according to `mode_M`.

## Interface
- `TIMEOUT`, default 255: maximum cycles in BUSY waiting for `mem_ready` before the access is aborted. Must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `memRead_M`  in  1  load in M stage.
- `memWrite_M`  in  1  store in M stage. Never asserted together with `memRead_M`.
- `alu_rsl_M`  in  32  byte address.
- `write_Data_M`  in  32  store data, right-justified.
- `mode_M`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- `stall_M`  out  1  holds IF/ID/EX/M registers (combinational).
- `load_data_M`  out  32  aligned and extended load result. Valid in DONE.
- `misalign_err`  out  1  one-cycle pulse: misaligned or illegal-mode access was dropped.
- `bus_err`  out  1  one-cycle pulse: timeout abort.
- `mem_req`  out  1  request valid (registered).
- `mem_we`  out  1  write enable (registered).
- `mem_addr`  out  32  word address `{alu_rsl_M[31:2],2'b00}` (registered).
- `mem_wdata`  out  32  lane-replicated store data (registered).
- `mem_wstrb`  out  4  byte strobes; 0 for reads (registered).
- `mem_ready`  in  1  memory accepts the write or returns read data this cycle.
- `mem_rdata`  in  32  read word. Valid when `mem_ready`=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE.**
  - Access = `memRead_M|memWrite_M`.
  - Legal access:
    - `stall_M`=1 combinationally.
    - At the clock edge, latch `mem_req`=1, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`; clear the timeout counter; go to BUSY.
  - Misaligned access (H/HU with addr[0]=1; W with addr[1:0]≠0) or illegal mode:
    - No request, `stall_M`=0.
    - `misalign_err`=1 in the same cycle (combinational); the instruction proceeds.
  - No access: stay in IDLE, `stall_M`=0.
- **BUSY.**
  - `stall_M`=1. `mem_*` outputs are held stable until `mem_ready`.
  - On `mem_ready`=1:
    - Register `mem_rdata` (reads only).
    - Deassert `mem_req` at the same edge; go to DONE.
  - On counter = TIMEOUT−1 without `mem_ready`:
    - Deassert `mem_req`; load result register = 0.
    - `bus_err` pulses 1 in the DONE cycle; go to DONE.
  - `mem_ready` in the timeout cycle wins; no error.
- **DONE.**
  - `stall_M`=0 and `load_data_M` is valid, so the pipeline advances at this edge.
  - Unconditionally return to IDLE. The next M-stage instruction is evaluated in IDLE on the following cycle.
- **Store encoding.**
  - B: wdata = byte replicated ×4; wstrb = 0001 << addr[1:0].
  - H: wdata = half replicated ×2; wstrb = 0011 << addr[1:0].
  - W: wdata = data; wstrb = 1111.
- **Load extraction.** Lane selected by addr[1:0] (from latched `mem_addr` low bits, kept internally).
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Outside DONE, `load_data_M` holds its last value.

## Timing
- Reset (synchronous, `rst_n`=0 at an edge): state=IDLE, counter=0, `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`/`load_data_M`=0, `mem_wstrb`=0. `bus_err`=0, `stall_M`=0 (no access pending), `misalign_err` follows inputs.
- Reset during BUSY aborts the access: `mem_req`=0 from the next cycle, no error pulse.
- Latency: with `mem_ready` in the first BUSY cycle, an access occupies 3 cycles (IDLE, BUSY, DONE); `stall_M` is high for 2.
- In general: `stall_M` high for 1 + (BUSY cycles); the pipeline advances exactly once per access.
- Back-to-back memory instructions: DONE → IDLE → BUSY. Each access costs at least 3 cycles.
- Handshake: once `mem_req`=1, none of `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb` changes until the cycle after `mem_ready`. `mem_req` is never asserted in IDLE or DONE.
- Timeout counter is 8 bits wide minimum, sized to ceil(log2(TIMEOUT+1)). It does not wrap.

## Test plan
- LW addr 0x100, `mem_ready` 2 cycles after `mem_req`, rdata 0xDEADBEEF:
  - `mem_addr`=0x100, `mem_wstrb`=0.
  - `stall_M` high 3 cycles.
  - `load_data_M`=0xDEADBEEF in DONE.
- SB addr 0x203, data 0x000000A5, ready immediate:
  - `mem_we`=1, `mem_addr`=0x200, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5.
- LB addr 0x101, rdata 0x0000_80_00 → `load_data_M`=0xFFFFFF80.
- LHU addr 0x102, rdata 0x8001_0000 → `load_data_M`=0x00008001.
- LW addr 0x102:
  - `misalign_err`=1 for one cycle.
  - `mem_req` stays 0 and `stall_M`=0.
- TIMEOUT=4, `mem_ready` never asserted:
  - `mem_req` high 4 cycles, then 0.
  - `bus_err`=1 one cycle; `load_data_M`=0; `stall_M` drops.
- Assert `rst_n`=0 mid-BUSY:
  - Next cycle `mem_req`=0, `stall_M`=0, state IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Memory-stage sequencer for the pipelined RV32I core. Runs the load/store held
// in the EX/M register as one transaction on a multi-cycle data-memory port and
// freezes the pipeline (stall_M) while the access is outstanding. It builds the
// byte strobes and lane-replicated store data, and aligns and extends the load
// result according to the funct3 access mode.
//
// Handshake: mem_req is the valid of a valid/ready pair. Once mem_req is high,
// mem_we/mem_addr/mem_wdata/mem_wstrb stay stable until the cycle after
// mem_ready is sampled high. A transfer completes on the first clock edge where
// mem_req and mem_ready are both 1. mem_req is only ever high in BUSY.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   memRead_M         load in M stage
//   memWrite_M        store in M stage (never together with memRead_M)
//   alu_rsl_M         byte address
//   write_Data_M      right-justified store data
//   mode_M            funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   stall_M           holds IF/ID/EX/M registers (combinational)
//   load_data_M       aligned/extended load result, valid in DONE
//   misalign_err      pulse: misaligned or illegal-mode access dropped
//   bus_err           pulse in DONE: access aborted by timeout
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   registered request
//   mem_ready, mem_rdata                          memory response
//   dbg_state_o       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic [31:0] alu_rsl_M,
    input  logic [31:0] write_Data_M,
    input  logic [2:0]  mode_M,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);

    // Counter is at least 8 bits, wider only if TIMEOUT needs it.
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [29:0]   waddr_q, waddr_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [2:0]    mode_q, mode_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   load_q, load_d;
    logic          bus_err_q, bus_err_d;

    logic          access;
    logic          mode_legal;
    logic          misaligned;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ld_ext;

    // -------------------------------------------------------------------------
    // Access classification in IDLE
    // -------------------------------------------------------------------------
    assign access = memRead_M | memWrite_M;

    always_comb begin
        mode_legal = 1'b0;
        misaligned = 1'b0;
        case (mode_M)
            3'b000, 3'b100: mode_legal = 1'b1;
            3'b001, 3'b101: begin
                mode_legal = 1'b1;
                misaligned = alu_rsl_M[0];
            end
            3'b010: begin
                mode_legal = 1'b1;
                misaligned = (alu_rsl_M[1:0] != 2'b00);
            end
            default: mode_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Store encoding: replicate the datum across every lane so the strobe alone
    // picks the destination bytes.
    // -------------------------------------------------------------------------
    always_comb begin
        st_wdata = write_Data_M;
        st_wstrb = 4'b1111;
        case (mode_M[1:0])
            2'b00: begin
                st_wdata = {4{write_Data_M[7:0]}};
                st_wstrb = 4'b0001 << alu_rsl_M[1:0];
            end
            2'b01: begin
                st_wdata = {2{write_Data_M[15:0]}};
                st_wstrb = 4'b0011 << alu_rsl_M[1:0];
            end
            default: begin
                st_wdata = write_Data_M;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load extraction from the returned word, using the latched byte offset
    // and mode (halfword offsets are even, so addr_lo_q[1] picks the half).
    // -------------------------------------------------------------------------
    always_comb begin
        lane_b = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mode_q)
            3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_ext = {24'h000000, lane_b};
            3'b101:  ld_ext = {16'h0000, lane_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        waddr_d      = waddr_q;
        addr_lo_d    = addr_lo_q;
        mode_d       = mode_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        load_d       = load_q;
        bus_err_d    = 1'b0;
        stall_M      = 1'b0;
        misalign_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (!mode_legal || misaligned) begin
                        // Dropped: the instruction proceeds without a request.
                        misalign_err = 1'b1;
                    end else begin
                        stall_M   = 1'b1;
                        req_d     = 1'b1;
                        we_d      = memWrite_M;
                        waddr_d   = alu_rsl_M[31:2];
                        addr_lo_d = alu_rsl_M[1:0];
                        mode_d    = mode_M;
                        wdata_d   = st_wdata;
                        wstrb_d   = memWrite_M ? st_wstrb : 4'b0000;
                        cnt_d     = '0;
                        state_d   = BUSY;
                    end
                end
            end

            BUSY: begin
                stall_M = 1'b1;
                // A response in the last allowed cycle still counts as success.
                if (mem_ready) begin
                    req_d   = 1'b0;
                    if (!we_q) begin
                        load_d = ld_ext;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    load_d    = 32'h0000_0000;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                // Pipeline advances at this edge; next instruction seen in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= 30'h0;
            addr_lo_q <= 2'b00;
            mode_q    <= 3'b000;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'b0000;
            load_q    <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            addr_lo_q <= addr_lo_d;
            mode_q    <= mode_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            load_q    <= load_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = {waddr_q, 2'b00};
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign load_data_M = load_q;
    assign bus_err     = bus_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Self-checking bench for dmem_access_ctrl (TIMEOUT=4). A responder task plays
// the memory with a per-access latency; load results are predicted into exp_q
// when an access is issued and compared with what the DUT presents in DONE.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        memRead_M = 1'b0;
    logic        memWrite_M = 1'b0;
    logic [31:0] alu_rsl_M = 32'h0;
    logic [31:0] write_Data_M = 32'h0;
    logic [2:0]  mode_M = 3'b000;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        stall_M;
    logic [31:0] load_data_M;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  dbg_state_o;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memRead_M    (memRead_M),
        .memWrite_M   (memWrite_M),
        .alu_rsl_M    (alu_rsl_M),
        .write_Data_M (write_Data_M),
        .mode_M       (mode_M),
        .stall_M      (stall_M),
        .load_data_M  (load_data_M),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .dbg_state_o  (dbg_state_o)
    );

    // -------------------------------------------------------------------------
    // Scoreboard and observation state
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    int          obs_stall;
    int          obs_req;
    int          obs_misalign;
    int          obs_buserr;
    int          obs_unstable;
    bit          obs_done;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    // Independent reference model (byte-loop formulation).
    function automatic int size_of(input logic [2:0] m);
        if (m[1:0] == 2'b00) return 1;
        if (m[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] m, input logic [1:0] a);
        logic [3:0] s;
        int n;
        s = 4'b0000;
        n = size_of(m);
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(a) && b < int'(a) + n) s[b] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] m, input logic [31:0] d);
        logic [31:0] w;
        int n;
        w = 32'h0;
        n = size_of(m);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] m, input logic [1:0] a,
                                               input logic [31:0] r);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = size_of(m);
        for (int b = 0; b < n; b++) v[8*b +: 8] = r[8*(int'(a) + b) +: 8];
        if (!m[2] && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Driver: presents one M-stage instruction and plays the memory. ready_at is
    // the BUSY cycle (1-based) in which mem_ready is raised; 0 means never.
    // Returns at the DONE cycle (or immediately if the access was dropped).
    // -------------------------------------------------------------------------
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [2:0] mode,
                              input int ready_at, input logic [31:0] rdata);
        obs_stall = 0; obs_req = 0; obs_misalign = 0; obs_buserr = 0;
        obs_unstable = 0; obs_done = 1'b0;
        @(negedge clk);
        memRead_M = rd; memWrite_M = wr; alu_rsl_M = addr;
        write_Data_M = data; mode_M = mode; mem_ready = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall_M) obs_stall++;
            if (misalign_err) obs_misalign++;
            if (bus_err) obs_buserr++;
            if (c == 0 && !stall_M) begin
                obs_done = 1'b1;
                break;
            end
            if (dbg_state_o == 2'd2) begin
                obs_done = 1'b1;
                if (rd) got_q.push_back(load_data_M);
                mem_ready = 1'b0;
                break;
            end
            if (mem_req) begin
                obs_req++;
                if (obs_req == 1) begin
                    cap_we = mem_we; cap_addr = mem_addr;
                    cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
                end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                             mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
                    obs_unstable++;
                end
                mem_ready = (obs_req == ready_at);
                mem_rdata = mem_ready ? rdata : $urandom();
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        memRead_M = 1'b0; memWrite_M = 1'b0; mem_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %b expected 0000", mem_wstrb); end
        checks++; if (load_data_M !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", load_data_M); end
        checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_M); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_buserr: got %b expected 0", bus_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        exp_q.push_back(32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 2, 32'hDEADBEEF);
        checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL lw_done: got %b expected 1", obs_done); end
        checks++; if (cap_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h expected 00000100", cap_addr); end
        checks++; if (cap_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_wstrb: got %b expected 0000", cap_wstrb); end
        checks++; if (cap_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b expected 0", cap_we); end
        checks++; if (obs_stall != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected 3", obs_stall); end
        checks++; if (obs_req != 2) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 2", obs_req); end
        checks++; if (obs_unstable != 0) begin errors++; $display("FAIL lw_stable: got %0d changes expected 0", obs_unstable); end
        checks++; if (obs_buserr != 0) begin errors++; $display("FAIL lw_buserr: got %0d expected 0", obs_buserr); end
        if (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [31:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL lw_load: got %h expected %h", g, e); end
        end else begin
            checks++; errors++; $display("FAIL lw_load: got no result expected one");
        end
        idle_inputs();
    endtask

    task automatic test_sb();
        run_access(1'b0, 1'b1, 32'h203, 32'h000000A5, 3'b000, 1, 32'h0);
        checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", cap_we); end
        checks++; if (cap_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h expected 00000200", cap_addr); end
        checks++; if (cap_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b expected 1000", cap_wstrb); end
        checks++; if (cap_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", cap_wdata); end
        checks++; if (obs_stall != 2) begin errors++; $display("FAIL sb_stall_cycles: got %0d expected 2", obs_stall); end
        idle_inputs();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_req_idle: got %b expected 0", mem_req); end
    endtask

    task automatic test_sub_word_loads();
        logic [31:0] e, g;
        exp_q.push_back(32'hFFFFFF80);
        run_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 1, 32'h0000_8000);
        exp_q.push_back(32'h00008001);
        run_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 1, 32'h8001_0000);
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL subword_load%0d: got %h expected %h", i, g, e); end
            end else begin
                checks++; errors++; $display("FAIL subword_load%0d: got no result expected one", i);
            end
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 1, 32'h0);
        checks++; if (obs_misalign != 1) begin errors++; $display("FAIL lw_mis_err: got %0d expected 1", obs_misalign); end
        checks++; if (obs_stall != 0) begin errors++; $display("FAIL lw_mis_stall: got %0d expected 0", obs_stall); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req: got %b expected 0", mem_req); end
        run_access(1'b0, 1'b1, 32'h301, 32'h0, 3'b001, 1, 32'h0);
        checks++; if (obs_misalign != 1) begin errors++; $display("FAIL sh_mis_err: got %0d expected 1", obs_misalign); end
        run_access(1'b1, 1'b0, 32'h300, 32'h0, 3'b011, 1, 32'h0);
        checks++; if (obs_misalign != 1) begin errors++; $display("FAIL illegal_mode_err: got %0d expected 1", obs_misalign); end
        idle_inputs();
        #1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
        checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL mis_state: got %0d expected 0", dbg_state_o); end
    endtask

    task automatic test_timeout();
        logic [31:0] e, g;
        // Preload a nonzero result so the abort's zero is observable.
        exp_q.push_back(32'h00008001);
        run_access(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 1, 32'h8001_0000);
        exp_q.push_back(32'h00000000);
        run_access(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 0, 32'h0);
        checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL to_done: got %b expected 1", obs_done); end
        checks++; if (obs_req != TO) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", obs_req, TO); end
        checks++; if (obs_buserr != 1) begin errors++; $display("FAIL to_buserr: got %0d expected 1", obs_buserr); end
        checks++; if (obs_stall != TO + 1) begin errors++; $display("FAIL to_stall_cycles: got %0d expected %0d", obs_stall, TO + 1); end
        idle_inputs();
        #1;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_buserr_pulse: got %b expected 0", bus_err); end
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL to_load%0d: got %h expected %h", i, g, e); end
            end else begin
                checks++; errors++; $display("FAIL to_load%0d: got no result expected one", i);
            end
        end
        // Ready in the last allowed BUSY cycle still succeeds.
        exp_q.push_back(32'h12345678);
        run_access(1'b1, 1'b0, 32'h404, 32'h0, 3'b010, TO, 32'h12345678);
        idle_inputs();
        checks++; if (obs_buserr != 0) begin errors++; $display("FAIL to_last_ready_err: got %0d expected 0", obs_buserr); end
        if (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL to_last_ready_load: got %h expected %h", g, e); end
        end else begin
            checks++; errors++; $display("FAIL to_last_ready_load: got no result expected one");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, g;
        int s0;
        exp_q.push_back(32'h0000_00AB);
        run_access(1'b1, 1'b0, 32'h500, 32'h0, 3'b100, 1, 32'h1122_33AB);
        s0 = obs_stall;
        exp_q.push_back(32'hFFFF_8899);
        run_access(1'b1, 1'b0, 32'h506, 32'h0, 3'b001, 1, 32'h8899_7766);
        idle_inputs();
        checks++; if (s0 != 2 || obs_stall != 2) begin errors++; $display("FAIL b2b_stall: got %0d,%0d expected 2,2", s0, obs_stall); end
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL b2b_load%0d: got %h expected %h", i, g, e); end
            end else begin
                checks++; errors++; $display("FAIL b2b_load%0d: got no result expected one", i);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  ld_modes[5];
        logic [2:0]  m;
        logic [31:0] a, d, r, e, g;
        logic        is_rd;
        int          lat;
        ld_modes[0] = 3'b000; ld_modes[1] = 3'b001; ld_modes[2] = 3'b010;
        ld_modes[3] = 3'b100; ld_modes[4] = 3'b101;
        for (int i = 0; i < 24; i++) begin
            is_rd = 1'($urandom_range(0, 1));
            m     = is_rd ? ld_modes[$urandom_range(0, 4)] : ld_modes[$urandom_range(0, 2)];
            a     = $urandom();
            a     = a & ~(32'(size_of(m)) - 32'd1);
            d     = $urandom();
            r     = $urandom();
            lat   = $urandom_range(1, TO);
            if (is_rd) exp_q.push_back(model_load(m, a[1:0], r));
            run_access(is_rd, ~is_rd, a, d, m, lat, r);
            checks++; if (obs_stall != lat + 1) begin errors++; $display("FAIL rnd%0d_stall: got %0d expected %0d", i, obs_stall, lat + 1); end
            checks++; if (cap_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", i, cap_addr, {a[31:2], 2'b00}); end
            checks++; if (obs_unstable != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d expected 0", i, obs_unstable); end
            if (is_rd) begin
                checks++; if (cap_wstrb !== 4'b0000) begin errors++; $display("FAIL rnd%0d_rd_wstrb: got %b expected 0000", i, cap_wstrb); end
                if (exp_q.size() > 0 && got_q.size() > 0) begin
                    e = exp_q.pop_front(); g = got_q.pop_front();
                    checks++; if (g !== e) begin errors++; $display("FAIL rnd%0d_load: got %h expected %h", i, g, e); end
                end else begin
                    checks++; errors++; $display("FAIL rnd%0d_load: got no result expected one", i);
                end
            end else begin
                checks++; if (cap_wstrb !== model_strb(m, a[1:0])) begin errors++; $display("FAIL rnd%0d_wstrb: got %b expected %b", i, cap_wstrb, model_strb(m, a[1:0])); end
                checks++; if (cap_wdata !== model_wdata(m, d)) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", i, cap_wdata, model_wdata(m, d)); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        memRead_M = 1'b1; memWrite_M = 1'b0; alu_rsl_M = 32'h600; mode_M = 3'b010; mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_req_before: got %b expected 1", mem_req); end
        rst_n = 1'b0; memRead_M = 1'b0;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstbusy_req: got %b expected 0", mem_req); end
        checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL rstbusy_stall: got %b expected 0", stall_M); end
        checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL rstbusy_state: got %0d expected 0", dbg_state_o); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rstbusy_buserr: got %b expected 0", bus_err); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstbusy_after: got err=%b req=%b expected 0 0", bus_err, mem_req); end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_sub_word_loads();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
